// File: rtl/dff_response_checker_if.sv
// Observation and result bundle between a single-bit storage element harness and dff_response_checker.
interface dff_response_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             d_obs;
  logic             q_obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, num_samples, d_obs, q_obs,
    input  busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  start, num_samples, d_obs, q_obs,
    output busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/dff_response_checker.sv
// Compares a flop's q response against its d stimulus delayed by LATENCY cycles,
// counting mismatches and reporting pass/fail at the end of an N-sample run.
module dff_response_checker #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  dff_response_checker_if.slave bus
);

  localparam int unsigned FILL_W = 4;

  typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

  state_t             state_q, state_d;
  logic [LATENCY-1:0] exp_q, exp_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               mismatch_c;

  // Expected-value pipeline shifts every cycle regardless of state
  if (LATENCY > 1) begin : g_shift
    assign exp_d = {exp_q[LATENCY-2:0], bus.d_obs};
  end else begin : g_single
    assign exp_d = bus.d_obs;
  end

  assign mismatch_c = (bus.q_obs != exp_q[LATENCY-1]);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    n_d     = n_q;
    k_d     = k_q;
    err_d   = err_q;
    first_d = first_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          n_d     = bus.num_samples;
          k_d     = '0;
          err_d   = '0;
          first_d = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          if (bus.num_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else if (LATENCY == 1) begin
            state_d = CHECK;
          end else begin
            state_d = ARM;
            fill_d  = FILL_W'(LATENCY - 1);
          end
        end
      end
      ARM: begin
        fill_d = fill_q - FILL_W'(1);
        if (fill_q == FILL_W'(1)) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q == '0) first_d = k_q;
          if (err_q != '1) err_d = err_q + CNT_W'(1);
        end
        k_d = k_q + CNT_W'(1);
        // Final compare: done and pass settle on the same edge
        if (k_q == n_q - CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ARM) || (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      exp_q   <= '0;
      fill_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      fill_q  <= fill_d;
      n_q     <= n_d;
      k_q     <= k_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule
